bsg_manycore_cache_pkt_buffer_profiler: RTL and testbench

//   Two-entry elastic buffer inserted between bsg_manycore_link_to_cache (upstream) and
//   bsg_cache (downstream) on the cache packet channel. Cuts the combinational ready path

---
 rtl/bsg_manycore_cache_pkt_buffer_profiler.sv | 145 ++++++++++++++
 tb/tb_bsg_manycore_cache_pkt_buffer_profiler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_cache_pkt_buffer_profiler.sv
// -----------------------------------------------------------------------------
// bsg_manycore_cache_pkt_buffer_profiler
//
// Two-entry elastic buffer on the cache packet channel between
// bsg_manycore_link_to_cache (upstream) and bsg_cache (downstream). The
// handshake outputs come from registered state only, so the cache's ready
// does not reach back into the link combinationally. Packets pass through
// unmodified and in order. The block also keeps saturating profiling
// counters of dequeued loads (LM), stores (SM) and other ops, and of
// back-pressure cycles.
//
// Packet layout (bsg_cache_pkt_s, MSB first): {opcode[5:0], addr, data, mask}
//
// Ports
//   clk_i          clock, all logic on posedge
//   reset_n_i      asynchronous active-low reset
//   cache_pkt_i    packet from link_to_cache
//   v_i            cache_pkt_i valid
//   ready_o        buffer can accept (enqueue on v_i & ready_o)
//   cache_pkt_o    head packet to bsg_cache
//   v_o            head valid
//   ready_i        cache accepts (dequeue on v_o & ready_i)
//   clear_i        synchronous clear of all counters
//   ld_count_o     dequeued LM packets
//   st_count_o     dequeued SM packets
//   other_count_o  dequeued packets of any other opcode
//   stall_count_o  cycles with v_o & ~ready_i
//   occupancy_o    entries held (0..2)
// -----------------------------------------------------------------------------
module bsg_manycore_cache_pkt_buffer_profiler #(
   parameter int addr_width_p = 28,
   parameter int data_width_p = 32,
   parameter int ctr_width_p  = 32,
   localparam int pkt_width_lp = 6 + addr_width_p + data_width_p + data_width_p/8
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [pkt_width_lp-1:0] cache_pkt_i,
   input  logic                    v_i,
   output logic                    ready_o,
   output logic [pkt_width_lp-1:0] cache_pkt_o,
   output logic                    v_o,
   input  logic                    ready_i,
   input  logic                    clear_i,
   output logic [ctr_width_p-1:0]  ld_count_o,
   output logic [ctr_width_p-1:0]  st_count_o,
   output logic [ctr_width_p-1:0]  other_count_o,
   output logic [ctr_width_p-1:0]  stall_count_o,
   output logic [1:0]              occupancy_o
);

   // Opcode encodings from bsg_cache_pkg
   localparam logic [5:0] op_lm_lp = 6'b001100;
   localparam logic [5:0] op_sm_lp = 6'b001101;
   localparam logic [ctr_width_p-1:0] ctr_one_lp = ctr_width_p'(1);

   // Storage is intentionally not reset; v_o qualifies cache_pkt_o.
   logic [pkt_width_lp-1:0] mem_q [2];

   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] occ_q, occ_d;
   logic       enq, deq;
   logic [5:0] head_op;

   // Gating with reset_n_i keeps ready_o low for the whole reset interval
   // even though the occupancy register already reads 0 at that point.
   assign ready_o     = reset_n_i & (occ_q != 2'd2);
   assign v_o         = (occ_q != 2'd0);
   assign cache_pkt_o = mem_q[rd_ptr_q];
   assign occupancy_o = occ_q;
   assign enq         = v_i & ready_o;
   assign deq         = v_o & ready_i;
   assign head_op     = cache_pkt_o[pkt_width_lp-1 -: 6];

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ enq;
      rd_ptr_d = rd_ptr_q ^ deq;
      occ_d    = occ_q;
      case ({enq, deq})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;      // idle, or simultaneous enq+deq at occupancy 1
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[wr_ptr_q] <= cache_pkt_i;
      end
   end

   // ---------------------------------------------------------------------
   // Profiling counters: 0 = ld, 1 = st, 2 = other, 3 = stall
   // ---------------------------------------------------------------------
   logic [3:0]                  ctr_inc;
   logic [3:0][ctr_width_p-1:0] ctr_all;

   assign ctr_inc[0] = deq & (head_op == op_lm_lp);
   assign ctr_inc[1] = deq & (head_op == op_sm_lp);
   assign ctr_inc[2] = deq & (head_op != op_lm_lp) & (head_op != op_sm_lp);
   assign ctr_inc[3] = v_o & ~ready_i;

   for (genvar gi = 0; gi < 4; gi++) begin : g_ctr
      logic [ctr_width_p-1:0] cnt_q, cnt_d;

      // Clear takes priority over a coincident increment; all-ones sticks.
      always_comb begin
         cnt_d = cnt_q;
         if (clear_i) begin
            cnt_d = '0;
         end else if (ctr_inc[gi] && !(&cnt_q)) begin
            cnt_d = cnt_q + ctr_one_lp;
         end
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign ctr_all[gi] = cnt_q;
   end

   assign ld_count_o    = ctr_all[0];
   assign st_count_o    = ctr_all[1];
   assign other_count_o = ctr_all[2];
   assign stall_count_o = ctr_all[3];

endmodule

// File: tb/tb_bsg_manycore_cache_pkt_buffer_profiler.sv
// -----------------------------------------------------------------------------
// Testbench for bsg_manycore_cache_pkt_buffer_profiler.
// A table of directed per-cycle vectors covers the basic pass-through and the
// full-buffer back-pressure case; hand-written sequences cover streaming,
// counter saturation (4-bit counters on a second instance), clear priority,
// asynchronous reset mid-operation, and a random run against a queue model.
// -----------------------------------------------------------------------------
module tb_bsg_manycore_cache_pkt_buffer_profiler;

   localparam int PW = 70;
   localparam logic [5:0] LM    = 6'b001100;
   localparam logic [5:0] SM    = 6'b001101;
   localparam logic [5:0] LW    = 6'b000010;
   localparam logic [5:0] TAGST = 6'b010000;
   localparam logic [5:0] TAGFL = 6'b010001;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [PW-1:0] pkt_i;
   logic          v_i, ready_i, clear_i;
   logic          ready_o, v_o;
   logic [PW-1:0] pkt_o;
   logic [31:0]   ld_o, st_o, oth_o, stall_o;
   logic [1:0]    occ_o;

   logic          v4, r4, c4;
   logic [PW-1:0] pkt4_i, pkt4_o;
   logic          ready4_o, v4_o;
   logic [3:0]    ld4_o, st4_o, oth4_o, stall4_o;
   logic [1:0]    occ4_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bsg_manycore_cache_pkt_buffer_profiler dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .cache_pkt_i(pkt_i), .v_i(v_i), .ready_o(ready_o),
      .cache_pkt_o(pkt_o), .v_o(v_o), .ready_i(ready_i),
      .clear_i(clear_i),
      .ld_count_o(ld_o), .st_count_o(st_o), .other_count_o(oth_o),
      .stall_count_o(stall_o), .occupancy_o(occ_o)
   );

   bsg_manycore_cache_pkt_buffer_profiler #(.ctr_width_p(4)) dut4 (
      .clk_i(clk), .reset_n_i(reset_n),
      .cache_pkt_i(pkt4_i), .v_i(v4), .ready_o(ready4_o),
      .cache_pkt_o(pkt4_o), .v_o(v4_o), .ready_i(r4),
      .clear_i(c4),
      .ld_count_o(ld4_o), .st_count_o(st4_o), .other_count_o(oth4_o),
      .stall_count_o(stall4_o), .occupancy_o(occ4_o)
   );

   typedef struct {
      logic        v;
      logic        rdy;
      logic [5:0]  op;
      logic [27:0] addr;
      logic        ev;
      logic        erdy;
      logic [1:0]  eocc;
      logic [5:0]  eop;
      logic [27:0] eaddr;
      logic [31:0] eld, est, eoth, estall;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [PW-1:0] mk(input logic [5:0] op, input logic [27:0] a);
      return {op, a, 32'(a) ^ 32'hA5A5_0000, 4'hF};
   endfunction

   function automatic vec_t mkv(input logic v, input logic rdy, input logic [5:0] op,
                                input logic [27:0] addr, input logic ev, input logic erdy,
                                input logic [1:0] eocc, input logic [5:0] eop,
                                input logic [27:0] eaddr, input logic [31:0] eld,
                                input logic [31:0] est, input logic [31:0] eoth,
                                input logic [31:0] estall);
      vec_t r;
      r.v = v; r.rdy = rdy; r.op = op; r.addr = addr;
      r.ev = ev; r.erdy = erdy; r.eocc = eocc; r.eop = eop; r.eaddr = eaddr;
      r.eld = eld; r.est = est; r.eoth = eoth; r.estall = estall;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic r, input logic c,
                        input logic [5:0] op, input logic [27:0] a);
      v_i = v; ready_i = r; clear_i = c; pkt_i = mk(op, a);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [PW-1:0] q [$];
   logic [5:0]    ops [10];

   initial begin
      logic [5:0]  rop;
      logic        rv, rr, exp_rdy;
      int          deqs, mld, mst, moth, mstall;

      reset_n = 1'b1;
      v_i = 1'b0; ready_i = 1'b0; clear_i = 1'b0; pkt_i = '0;
      v4 = 1'b0; r4 = 1'b0; c4 = 1'b0; pkt4_i = '0;

      //                v     rdy   op  addr      ev    erdy  occ   eop eaddr     ld     st     oth    stall
      tbl[0] = mkv(1'b1, 1'b1, LM, 28'h40,  1'b0, 1'b1, 2'd0, LM, 28'h0,   32'd0, 32'd0, 32'd0, 32'd0);
      tbl[1] = mkv(1'b0, 1'b1, LM, 28'h0,   1'b1, 1'b1, 2'd1, LM, 28'h40,  32'd0, 32'd0, 32'd0, 32'd0);
      tbl[2] = mkv(1'b1, 1'b0, SM, 28'h100, 1'b0, 1'b1, 2'd0, LM, 28'h0,   32'd1, 32'd0, 32'd0, 32'd0);
      tbl[3] = mkv(1'b1, 1'b0, SM, 28'h104, 1'b1, 1'b1, 2'd1, SM, 28'h100, 32'd1, 32'd0, 32'd0, 32'd0);
      tbl[4] = mkv(1'b1, 1'b0, SM, 28'h108, 1'b1, 1'b0, 2'd2, SM, 28'h100, 32'd1, 32'd0, 32'd0, 32'd1);
      tbl[5] = mkv(1'b1, 1'b0, SM, 28'h108, 1'b1, 1'b0, 2'd2, SM, 28'h100, 32'd1, 32'd0, 32'd0, 32'd2);
      tbl[6] = mkv(1'b0, 1'b1, SM, 28'h0,   1'b1, 1'b0, 2'd2, SM, 28'h100, 32'd1, 32'd0, 32'd0, 32'd3);
      tbl[7] = mkv(1'b0, 1'b1, SM, 28'h0,   1'b1, 1'b1, 2'd1, SM, 28'h104, 32'd1, 32'd1, 32'd0, 32'd3);
      tbl[8] = mkv(1'b0, 1'b0, SM, 28'h0,   1'b0, 1'b1, 2'd0, LM, 28'h0,   32'd1, 32'd2, 32'd0, 32'd3);

      ops = '{LM, SM, LM, LM, TAGST, SM, LM, LM, SM, LM};

      // ---------------- reset ----------------
      #1 reset_n = 1'b0;
      #1;
      chk("rst_ready", 70'(ready_o), 70'(1'b0));
      chk("rst_v", 70'(v_o), 70'(1'b0));
      chk("rst_occ", 70'(occ_o), 70'(2'd0));
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      step();

      // ---------------- table: single LM, then full-buffer stall ----------------
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].v, tbl[i].rdy, 1'b0, tbl[i].op, tbl[i].addr);
         chk($sformatf("t%0d_v", i), 70'(v_o), 70'(tbl[i].ev));
         chk($sformatf("t%0d_ready", i), 70'(ready_o), 70'(tbl[i].erdy));
         chk($sformatf("t%0d_occ", i), 70'(occ_o), 70'(tbl[i].eocc));
         chk($sformatf("t%0d_ld", i), 70'(ld_o), 70'(tbl[i].eld));
         chk($sformatf("t%0d_st", i), 70'(st_o), 70'(tbl[i].est));
         chk($sformatf("t%0d_oth", i), 70'(oth_o), 70'(tbl[i].eoth));
         chk($sformatf("t%0d_stall", i), 70'(stall_o), 70'(tbl[i].estall));
         if (tbl[i].ev) chk($sformatf("t%0d_pkt", i), pkt_o, mk(tbl[i].eop, tbl[i].eaddr));
         $display("vec %0d: v_i=%0b ready_i=%0b -> v_o=%0b ready_o=%0b occ=%0d", i,
                  tbl[i].v, tbl[i].rdy, v_o, ready_o, occ_o);
         step();
      end

      // ---------------- streaming at occupancy 1, clear on first dequeue -------
      q.delete();
      drive(1'b1, 1'b0, 1'b0, TAGFL, 28'h300);
      q.push_back(mk(TAGFL, 28'h300));
      step();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, (i == 0), ops[i], 28'(32'h400 + 4 * i));
         chk($sformatf("s%0d_occ", i), 70'(occ_o), 70'(2'd1));
         chk($sformatf("s%0d_v", i), 70'(v_o), 70'(1'b1));
         chk($sformatf("s%0d_pkt", i), pkt_o, q[0]);
         if (i == 1) begin
            chk("clr_wins_oth", 70'(oth_o), 70'(0));
            chk("clr_wins_ld", 70'(ld_o), 70'(0));
         end
         $display("stream %0d: out=%0h", i, pkt_o);
         void'(q.pop_front());
         q.push_back(mk(ops[i], 28'(32'h400 + 4 * i)));
         step();
      end
      drive(1'b0, 1'b1, 1'b0, LM, 28'h0);
      chk("drain_pkt", pkt_o, q[0]);
      void'(q.pop_front());
      step();
      chk("strm_occ", 70'(occ_o), 70'(2'd0));
      chk("strm_ld", 70'(ld_o), 70'(6));
      chk("strm_st", 70'(st_o), 70'(3));
      chk("strm_oth", 70'(oth_o), 70'(1));
      chk("strm_stall", 70'(stall_o), 70'(0));
      drive(1'b0, 1'b0, 1'b0, LM, 28'h0);

      // ---------------- 4-bit counter saturation and clear ----------------
      deqs = 0;
      for (int k = 0; k <= 20; k++) begin
         v4 = (k < 20); r4 = 1'b1; pkt4_i = mk(LM, 28'(32'h800 + k));
         chk($sformatf("sat%0d_ld", k), 70'(ld4_o), 70'((deqs > 15) ? 15 : deqs));
         step();
         if (k >= 1) deqs++;
      end
      v4 = 1'b0;
      chk("sat_final", 70'(ld4_o), 70'(4'd15));
      $display("saturation: %0d dequeues, ld_count=%0d", deqs, ld4_o);
      v4 = 1'b1; r4 = 1'b0; pkt4_i = mk(LM, 28'h900);
      step();
      v4 = 1'b0; r4 = 1'b1; c4 = 1'b1;
      chk("clr4_v", 70'(v4_o), 70'(1'b1));
      chk("clr4_ld_before", 70'(ld4_o), 70'(4'd15));
      step();
      c4 = 1'b0;
      chk("clr4_ld", 70'(ld4_o), 70'(4'd0));
      chk("clr4_occ", 70'(occ4_o), 70'(2'd0));

      // ---------------- async reset mid-operation ----------------
      drive(1'b1, 1'b0, 1'b0, SM, 28'h500);
      step();
      drive(1'b1, 1'b0, 1'b0, SM, 28'h504);
      step();
      chk("pre_rst_occ", 70'(occ_o), 70'(2'd2));
      chk("pre_rst_st", 70'(st_o), 70'(3));
      chk("pre_rst_stall", 70'(stall_o), 70'(1));
      #3 reset_n = 1'b0;
      #2;
      chk("arst_v", 70'(v_o), 70'(1'b0));
      chk("arst_ready", 70'(ready_o), 70'(1'b0));
      chk("arst_occ", 70'(occ_o), 70'(2'd0));
      chk("arst_ld", 70'(ld_o), 70'(0));
      chk("arst_st", 70'(st_o), 70'(0));
      chk("arst_oth", 70'(oth_o), 70'(0));
      chk("arst_stall", 70'(stall_o), 70'(0));
      drive(1'b0, 1'b0, 1'b0, LM, 28'h0);
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      #1;
      chk("rel_ready", 70'(ready_o), 70'(1'b1));
      @(posedge clk);
      #1;
      chk("rel_occ", 70'(occ_o), 70'(2'd0));
      chk("rel_v", 70'(v_o), 70'(1'b0));
      chk("rel_ready2", 70'(ready_o), 70'(1'b1));

      // ---------------- random traffic against a queue model ----------------
      q.delete();
      mld = 0; mst = 0; moth = 0; mstall = 0;
      for (int c = 0; c < 10000; c++) begin
         rv = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       rop = LM;
            1:       rop = SM;
            2:       rop = LW;
            default: rop = TAGST;
         endcase
         v_i = rv; ready_i = rr; clear_i = 1'b0;
         pkt_i = mk(rop, 28'($urandom));
         exp_rdy = (q.size() != 2);
         chk($sformatf("r%0d_ready", c), 70'(ready_o), 70'(exp_rdy));
         chk($sformatf("r%0d_v", c), 70'(v_o), 70'(q.size() != 0));
         chk($sformatf("r%0d_occ", c), 70'(occ_o), 70'(q.size()));
         if (q.size() != 0) chk($sformatf("r%0d_pkt", c), pkt_o, q[0]);
         #3 ready_i = ~rr;
         #1;
         chk($sformatf("r%0d_ready_comb", c), 70'(ready_o), 70'(exp_rdy));
         ready_i = rr;
         if (q.size() != 0) begin
            if (rr) begin
               if (q[0][PW-1 -: 6] == LM) mld++;
               else if (q[0][PW-1 -: 6] == SM) mst++;
               else moth++;
               void'(q.pop_front());
            end else begin
               mstall++;
            end
         end
         if (rv && exp_rdy) q.push_back(pkt_i);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, LM, 28'h0);
      chk("rnd_ld", 70'(ld_o), 70'(mld));
      chk("rnd_st", 70'(st_o), 70'(mst));
      chk("rnd_oth", 70'(oth_o), 70'(moth));
      chk("rnd_stall", 70'(stall_o), 70'(mstall));
      chk("rnd_occ", 70'(occ_o), 70'(q.size()));
      $display("random: ld=%0d st=%0d other=%0d stall=%0d", mld, mst, moth, mstall);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
